multimode_counter: RTL and testbench

MULTIMODE_COUNTER -- requirements
Module: multimode_counter

---
 rtl/multimode_counter_pkg.sv | 17 +
 rtl/multimode_counter_if.sv | 39 +++
 rtl/multimode_counter_gray2bin.sv | 22 ++
 rtl/multimode_counter.sv | 107 ++++++++++
 tb/tb_multimode_counter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multimode_counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_defs
// Shared definitions for the multimode counter: the count-mode encoding used
// by the RTL, its interface and the testbench.
// -----------------------------------------------------------------------------
package counter_defs;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_BIN  = 2'd0,   // plain binary up/down
        MODE_GRAY = 2'd1,   // gray-coded output of an internal binary count
        MODE_RING = 2'd2,   // one-hot rotate left
        MODE_JOHN = 2'd3    // johnson (twisted ring), period 2*WIDTH
    } mode_e;

endpackage : counter_defs

// File: rtl/multimode_counter_if.sv
// -----------------------------------------------------------------------------
// multimode_counter_if
// Groups the control inputs and count outputs of multimode_counter.
//   i_en       count enable
//   i_mode     requested count mode (mode_e)
//   i_dir      1 up / 0 down (binary and gray only)
//   i_clr      synchronous clear to the active mode's seed
//   i_load     synchronous load of i_load_val
//   i_load_val load value in the active mode's code
//   o_cnt      count value in the active mode's code
//   o_tc       terminal-count flag (combinational)
//   o_wrap     one-cycle pulse on wrap from terminal to seed
// Modports: master drives controls (bench/user), slave is the counter.
// -----------------------------------------------------------------------------
interface multimode_counter_if
    import counter_defs::*;
#(
    parameter int WIDTH = 4
);
    logic             i_en;
    mode_e            i_mode;
    logic             i_dir;
    logic             i_clr;
    logic             i_load;
    logic [WIDTH-1:0] i_load_val;
    logic [WIDTH-1:0] o_cnt;
    logic             o_tc;
    logic             o_wrap;

    modport master (
        output i_en, i_mode, i_dir, i_clr, i_load, i_load_val,
        input  o_cnt, o_tc, o_wrap
    );

    modport slave (
        input  i_en, i_mode, i_dir, i_clr, i_load, i_load_val,
        output o_cnt, o_tc, o_wrap
    );
endinterface : multimode_counter_if

// File: rtl/multimode_counter_gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Combinational gray-to-binary converter.
//   i_gray  WIDTH-bit gray code
//   o_bin   WIDTH-bit binary equivalent
// Each binary bit is the XOR of the gray bits at and above its position,
// written per bit so no bit depends on another output bit.
// -----------------------------------------------------------------------------
module gray2bin
    import counter_defs::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign o_bin[gi] = ^i_gray[WIDTH-1:gi];
        end
    endgenerate
endmodule : gray2bin

// File: rtl/multimode_counter.sv
// -----------------------------------------------------------------------------
// multimode_counter
// WIDTH-bit counter with binary, gray, ring and johnson modes.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    multimode_counter_if.slave (controls in, o_cnt/o_tc/o_wrap out)
// Per-edge priority: clear > mode change > load > enable > hold.
// In gray mode the register holds the binary count; o_cnt is its gray image.
// -----------------------------------------------------------------------------
module multimode_counter
    import counter_defs::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multimode_counter_if.slave    bus
);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MSB_ONE  = {1'b1, {(WIDTH-1){1'b0}}};

    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] cnt_out;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] seed_cur;
    logic             tc;
    logic             ring_onehot;

    // Seed value in internal representation (gray seed 0 is also binary 0).
    function automatic logic [WIDTH-1:0] seed_of(mode_e m);
        return (m == MODE_RING) ? ONE : '0;
    endfunction

    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .i_gray (bus.i_load_val),
        .o_bin  (load_bin)
    );

    assign seed_cur    = seed_of(mode_q);
    assign cnt_out     = (mode_q == MODE_GRAY) ? (cnt_q ^ (cnt_q >> 1)) : cnt_q;
    assign ring_onehot = (cnt_q != '0) && ((cnt_q & (cnt_q - ONE)) == '0);

    always_comb begin
        term_val = MSB_ONE;
        unique case (mode_q)
            MODE_BIN:  term_val = bus.i_dir ? ALL_ONES : '0;
            MODE_GRAY: term_val = bus.i_dir ? MSB_ONE  : '0;
            default:   term_val = MSB_ONE;
        endcase
    end

    assign tc = (cnt_out == term_val);

    // One enabled step from the current value.
    always_comb begin
        step_val = cnt_q;
        unique case (mode_q)
            MODE_BIN, MODE_GRAY: step_val = bus.i_dir ? (cnt_q + ONE) : (cnt_q - ONE);
            // A corrupted (non one-hot) ring value is repaired rather than rotated.
            MODE_RING:           step_val = ring_onehot ? {cnt_q[WIDTH-2:0], cnt_q[WIDTH-1]} : ONE;
            MODE_JOHN:           step_val = {cnt_q[WIDTH-2:0], ~cnt_q[WIDTH-1]};
            default:             step_val = cnt_q;
        endcase
    end

    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (bus.i_clr) begin
            cnt_d = seed_cur;
        end else if (bus.i_mode != mode_q) begin
            mode_d = bus.i_mode;
            cnt_d  = seed_of(bus.i_mode);
        end else if (bus.i_load) begin
            cnt_d = (mode_q == MODE_GRAY) ? load_bin : bus.i_load_val;
        end else if (bus.i_en) begin
            cnt_d  = step_val;
            // A wrap is a step out of the terminal value that lands on the seed;
            // a down-count leaving 0 lands on all-ones and is not a wrap.
            wrap_d = tc && (step_val == seed_cur);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_BIN;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.o_cnt  = cnt_out;
    assign bus.o_tc   = tc;
    assign bus.o_wrap = wrap_q;

endmodule : multimode_counter

// File: tb/tb_multimode_counter.sv
// -----------------------------------------------------------------------------
// tb_multimode_counter
// Self-checking bench for multimode_counter at WIDTH=4: directed sequences,
// a table of vectors with hand-derived expectations, and randomized cycles
// checked against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_multimode_counter;
    import counter_defs::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multimode_counter_if #(.WIDTH(W)) bus ();

    multimode_counter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Reference model: mode number and value; gray mode keeps the binary count.
    int m_mode, m_val, m_wrap;

    function automatic int m_seed(int md);
        return (md == 2) ? 1 : 0;
    endfunction

    function automatic int m_out();
        return (m_mode == 1) ? (m_val ^ (m_val >> 1)) : m_val;
    endfunction

    function automatic int m_tc(int dir);
        int o;
        o = m_out();
        case (m_mode)
            0:       return dir ? int'(o == 15) : int'(o == 0);
            1:       return dir ? int'(o == 8)  : int'(o == 0);
            default: return int'(o == 8);
        endcase
    endfunction

    function automatic int g2b(int g);
        int acc, b;
        acc = 0;
        b   = 0;
        for (int i = W - 1; i >= 0; i--) begin
            acc = acc ^ ((g >> i) & 1);
            b   = b | (acc << i);
        end
        return b;
    endfunction

    task automatic model_step(int en, int md, int dir, int clr, int ld, int lv);
        int was_tc;
        if (clr != 0) begin
            m_val  = m_seed(m_mode);
            m_wrap = 0;
        end else if (md != m_mode) begin
            m_mode = md;
            m_val  = m_seed(md);
            m_wrap = 0;
        end else if (ld != 0) begin
            m_val  = (m_mode == 1) ? g2b(lv) : lv;
            m_wrap = 0;
        end else if (en != 0) begin
            was_tc = m_tc(dir);
            case (m_mode)
                0, 1: m_val = (m_val + (dir ? 1 : 15)) % 16;
                2:    m_val = ($countones(m_val) == 1) ? ((m_val * 2) % 16 + m_val / 8) : 1;
                default: m_val = (m_val * 2) % 16 + ((m_val >= 8) ? 0 : 1);
            endcase
            m_wrap = (was_tc != 0 && m_val == m_seed(m_mode)) ? 1 : 0;
        end else begin
            m_wrap = 0;
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_val  = 0;
        m_wrap = 0;
    endtask

    task automatic check(string name, int act, int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(int en, int md, int dir, int clr, int ld, int lv);
        bus.i_en       = 1'(en);
        bus.i_mode     = mode_e'(2'(md));
        bus.i_dir      = 1'(dir);
        bus.i_clr      = 1'(clr);
        bus.i_load     = 1'(ld);
        bus.i_load_val = 4'(lv);
    endtask

    // One clock edge; model advances with the same inputs; outputs sampled #1 later.
    task automatic tick();
        model_step(int'(bus.i_en), int'(bus.i_mode), int'(bus.i_dir),
                   int'(bus.i_clr), int'(bus.i_load), int'(bus.i_load_val));
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc %0d en=%0d mode=%0d dir=%0d clr=%0d ld=%0d lv=%0d -> cnt=%0d tc=%0d wrap=%0d",
                 cyc, bus.i_en, bus.i_mode, bus.i_dir, bus.i_clr, bus.i_load, bus.i_load_val,
                 bus.o_cnt, bus.o_tc, bus.o_wrap);
    endtask

    typedef struct {
        int en, md, dir, clr, ld, lv;
        int cnt, wrap, tc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int en, int md, int dir, int clr, int ld, int lv,
                                int cnt, int wrap, int tc);
        vec_t v;
        v.en = en; v.md = md; v.dir = dir; v.clr = clr; v.ld = ld; v.lv = lv;
        v.cnt = cnt; v.wrap = wrap; v.tc = tc;
        return v;
    endfunction

    int gseq[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    int jseq[8]  = '{1, 3, 7, 15, 14, 12, 8, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev, md_req;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        drive(1, 0, 1, 0, 0, 0);
        model_reset();
        #12;
        check("reset cnt", int'(bus.o_cnt), 0);
        check("reset wrap", int'(bus.o_wrap), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- binary up 0..15,0 ----------------
        check("bin start tc", int'(bus.o_tc), 0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("bin up cnt k=%0d", k), int'(bus.o_cnt), k % 16);
            check($sformatf("bin up tc k=%0d", k), int'(bus.o_tc), (k == 15) ? 1 : 0);
            check($sformatf("bin up wrap k=%0d", k), int'(bus.o_wrap), (k == 16) ? 1 : 0);
        end

        // ---------------- gray up sequence ----------------
        drive(1, 1, 1, 0, 0, 0);
        tick();
        check("gray reseed cnt", int'(bus.o_cnt), 0);
        check("gray reseed wrap", int'(bus.o_wrap), 0);
        prev = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("gray cnt k=%0d", k), int'(bus.o_cnt), gseq[k]);
            check($sformatf("gray onebit k=%0d", k), $countones(int'(bus.o_cnt) ^ prev), 1);
            check($sformatf("gray tc k=%0d", k), int'(bus.o_tc), (gseq[k] == 8) ? 1 : 0);
            check($sformatf("gray wrap k=%0d", k), int'(bus.o_wrap), (k == 16) ? 1 : 0);
            prev = int'(bus.o_cnt);
        end

        // ---------------- table of vectors ----------------
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0, 0, 1));  // back to binary, down: tc at 0
        tbl.push_back(mk(1, 0, 0, 0, 1, 3,   3, 0, 0));  // load beats enable
        tbl.push_back(mk(1, 0, 0, 1, 1, 9,   0, 0, 1));  // clear beats load
        tbl.push_back(mk(0, 1, 1, 0, 0, 0,   0, 0, 0));  // to gray
        tbl.push_back(mk(0, 1, 1, 0, 1, 12, 12, 0, 0));  // load gray 1100
        tbl.push_back(mk(1, 1, 1, 0, 0, 0,  13, 0, 0));  // up -> 1101
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  13, 0, 0));  // hold
        tbl.push_back(mk(1, 1, 0, 0, 0, 0,  12, 0, 0));  // down immediately
        tbl.push_back(mk(0, 0, 1, 0, 0, 0,   0, 0, 0));  // to binary
        tbl.push_back(mk(0, 0, 1, 0, 1, 5,   5, 0, 0));  // load 5
        tbl.push_back(mk(1, 2, 1, 0, 0, 0,   1, 0, 0));  // to ring: reseed, en ignored
        tbl.push_back(mk(1, 2, 1, 0, 0, 0,   2, 0, 0));
        tbl.push_back(mk(1, 2, 1, 0, 0, 0,   4, 0, 0));
        tbl.push_back(mk(1, 2, 1, 0, 0, 0,   8, 0, 1));
        tbl.push_back(mk(1, 2, 1, 0, 0, 0,   1, 1, 0));  // ring wrap
        tbl.push_back(mk(0, 2, 1, 0, 1, 6,   6, 0, 0));  // load non-one-hot
        tbl.push_back(mk(1, 2, 1, 0, 0, 0,   1, 0, 0));  // corrected
        tbl.push_back(mk(1, 2, 0, 1, 0, 0,   1, 0, 0));  // clear to ring seed
        tbl.push_back(mk(1, 3, 1, 0, 0, 0,   0, 0, 0));  // to johnson
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(1, 3, 0, 0, 0, 0, jseq[k], (k == 7) ? 1 : 0, (jseq[k] == 8) ? 1 : 0));
        tbl.push_back(mk(1, 3, 1, 0, 1, 8,   8, 0, 1));  // load terminal: no wrap
        tbl.push_back(mk(1, 3, 1, 1, 0, 0,   0, 0, 0));  // clear: no wrap

        foreach (tbl[i]) begin
            drive(tbl[i].en, tbl[i].md, tbl[i].dir, tbl[i].clr, tbl[i].ld, tbl[i].lv);
            tick();
            check($sformatf("vec%0d cnt", i), int'(bus.o_cnt), tbl[i].cnt);
            check($sformatf("vec%0d wrap", i), int'(bus.o_wrap), tbl[i].wrap);
            check($sformatf("vec%0d tc", i), int'(bus.o_tc), tbl[i].tc);
        end

        // ---------------- async reset mid-count ----------------
        drive(0, 0, 1, 1, 0, 0);
        tick();
        drive(1, 0, 1, 0, 0, 0);
        tick();  // mode change from johnson to binary
        for (int k = 0; k < 7; k++) tick();
        check("pre-reset cnt", int'(bus.o_cnt), 7);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async reset cnt", int'(bus.o_cnt), 0);
        check("async reset wrap", int'(bus.o_wrap), 0);
        drive(1, 3, 1, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post-reset reseed cnt", int'(bus.o_cnt), 0);
        tick();
        check("post-reset johnson step", int'(bus.o_cnt), 1);

        // ---------------- randomized against model ----------------
        md_req = 3;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(7) == 0) md_req = int'($urandom_range(3));
            drive(($urandom_range(3) != 0) ? 1 : 0, md_req, int'($urandom_range(1)),
                  ($urandom_range(15) == 0) ? 1 : 0, ($urandom_range(7) == 0) ? 1 : 0,
                  int'($urandom_range(15)));
            tick();
            check($sformatf("rand%0d cnt", k), int'(bus.o_cnt), m_out());
            check($sformatf("rand%0d wrap", k), int'(bus.o_wrap), m_wrap);
            check($sformatf("rand%0d tc", k), int'(bus.o_tc), m_tc(int'(bus.i_dir)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule : tb_multimode_counter
